// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage RISC-V core.
//  - Resolves source operands in ID from the forwarding-unit selects.
//  - Detects the hazards forwarding cannot cover (writer still in EX,
//    load in MEM), stalls IF/ID and inserts a bubble into EX.
//  - A branch/jump flush from EX overrides everything but reset.
// Optional build macro: ID_EX_STALL_COUNT_EN adds stall_count / flush_count.
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               valid_ID,
    input  logic [RA_W-1:0]    rs1_ID,
    input  logic [RA_W-1:0]    rs2_ID,
    input  logic [RA_W-1:0]    rd_ID,
    input  logic               uses_rs1_ID,
    input  logic               uses_rs2_ID,
    input  logic [XLEN-1:0]    rs1_data_ID,
    input  logic [XLEN-1:0]    rs2_data_ID,
    input  logic [XLEN-1:0]    imm_ID,
    input  logic [XLEN-1:0]    pc_ID,
    input  logic               alu_src_ID,
    input  logic [ALUOP_W-1:0] alu_op_ID,
    input  logic               mem_read_ID,
    input  logic               mem_write_ID,
    input  logic               reg_WB_ID,

    input  logic [1:0]         forward_A,
    input  logic [1:0]         forward_B,
    input  logic [XLEN-1:0]    alu_result_MEM,
    input  logic [XLEN-1:0]    wb_data_WB,
    input  logic [RA_W-1:0]    rd_MEM,
    input  logic               mem_read_MEM,
    input  logic               flush_EX,

    output logic               stall_IF_ID,
    output logic               valid_EX,
    output logic               mem_read_EX,
    output logic               mem_write_EX,
    output logic               reg_WB_EX,
    output logic [ALUOP_W-1:0] alu_op_EX,
    output logic [RA_W-1:0]    rd_EX,
    output logic [XLEN-1:0]    operand_a_EX,
    output logic [XLEN-1:0]    operand_b_EX,
    output logic [XLEN-1:0]    store_data_EX,
    output logic [XLEN-1:0]    pc_EX,
    output logic [XLEN-1:0]    imm_EX
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            hz;
    logic            bubble;

    // True when the ID instruction actually reads register r (x0 never counts).
    function automatic logic src_match(input logic [RA_W-1:0] r);
        return (r != '0) &&
               ((uses_rs1_ID && (rs1_ID == r)) || (uses_rs2_ID && (rs2_ID == r)));
    endfunction

    // Operand selection from register file or the forwarding paths.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fwd_a = rs1_data_ID;
        fwd_b = rs2_data_ID;
        case (forward_A)
            2'b01:   fwd_a = alu_result_MEM;
            2'b10:   fwd_a = wb_data_WB;
            default: fwd_a = rs1_data_ID;
        endcase
        case (forward_B)
            2'b01:   fwd_b = alu_result_MEM;
            2'b10:   fwd_b = wb_data_WB;
            default: fwd_b = rs2_data_ID;
        endcase
    end

    // Hazards forwarding cannot resolve: result not yet produced by EX, or load data not yet back from MEM.
    always_comb begin
        hz = valid_ID && !flush_EX &&
             ((src_match(rd_EX) && reg_WB_EX && valid_EX) ||
              (src_match(rd_MEM) && mem_read_MEM));
        // A flush redirects fetch, so holding IF/ID would keep the wrong-path instruction.
        bubble = flush_EX || hz;
    end

    // Stall is suppressed while reset is held so a reset mid-stall releases cleanly.
    assign stall_IF_ID = hz && rst_n;

    // Control half of the pipeline register: bubbles clear it, loads gate it with valid_ID.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            valid_EX     <= 1'b0;
            mem_read_EX  <= 1'b0;
            mem_write_EX <= 1'b0;
            reg_WB_EX    <= 1'b0;
            alu_op_EX    <= '0;
            rd_EX        <= '0;
        end else if (bubble) begin
            valid_EX     <= 1'b0;
            mem_read_EX  <= 1'b0;
            mem_write_EX <= 1'b0;
            reg_WB_EX    <= 1'b0;
            alu_op_EX    <= '0;
            rd_EX        <= '0;
        end else begin
            valid_EX     <= valid_ID;
            mem_read_EX  <= mem_read_ID  && valid_ID;
            mem_write_EX <= mem_write_ID && valid_ID;
            reg_WB_EX    <= reg_WB_ID    && valid_ID;
            alu_op_EX    <= valid_ID ? alu_op_ID : '0;
            rd_EX        <= rd_ID;
        end
    end

    // Data half: always loads outside reset; its contents are meaningless behind a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operand_a_EX  <= '0;
            operand_b_EX  <= '0;
            store_data_EX <= '0;
            pc_EX         <= '0;
            imm_EX        <= '0;
        end else begin
            operand_a_EX  <= fwd_a;
            operand_b_EX  <= alu_src_ID ? imm_ID : fwd_b;
            store_data_EX <= fwd_b;
            pc_EX         <= pc_ID;
            imm_EX        <= imm_ID;
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    // Free-running event counters; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hz)       stall_count <= stall_count + 32'd1;
            if (flush_EX) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
